// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth pair {q[0], q_m1}; 2'b11 behaves like BOOTH_NOP
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Command, product and shared add/sub unit signals of booth_mul_seq.
interface booth_mul_seq_if #(parameter int WIDTH = mul_pkg::MUL_WIDTH);
  logic               start_valid;
  logic               start_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic               add_is_sub;
  logic [WIDTH-1:0]   add_s;
  logic               add_ovfl;
  logic               prod_valid;
  logic               prod_ready;
  logic [2*WIDTH-1:0] prod;
  logic               busy;

  modport slave (
    input  start_valid, op_a, op_b, add_s, add_ovfl, prod_ready,
    output start_ready, add_a, add_b, add_cin, add_is_sub, prod_valid, prod, busy
  );

  modport master (
    output start_valid, op_a, op_b, add_s, add_ovfl, prod_ready,
    input  start_ready, add_a, add_b, add_cin, add_is_sub, prod_valid, prod, busy
  );
endinterface

// File: rtl/booth_step_dec.sv
// Radix-2 Booth step decode: selects the adder B operand and add/sub mode.
module booth_step_dec
  import mul_pkg::*;
(
  input  logic q0,
  input  logic q_m1,
  output logic sel_mcand,
  output logic is_sub
);

  logic [1:0] pair;
  assign pair = {q0, q_m1};

  always_comb begin
    sel_mcand = 1'b0;
    is_sub    = 1'b0;
    case (pair)
      BOOTH_ADD: sel_mcand = 1'b1;
      BOOTH_SUB: begin
        sel_mcand = 1'b1;
        is_sub    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth 16x16 signed multiplier on a shared CLA add/sub unit.
// Optional BOOTH_MUL_SEQ_ZERO_SKIP_EN: zero operands go straight to DONE.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc, q, mcand;
  logic               q_m1;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_q;

  logic               sel_mcand, step_sub, sgn;
  logic [WIDTH-1:0]   acc_next, q_next;
  logic               accept, zero_op, last_step;

  booth_step_dec u_dec (
    .q0        (q[0]),
    .q_m1      (q_m1),
    .sel_mcand (sel_mcand),
    .is_sub    (step_sub)
  );

  assign accept = bus.start_valid & bus.start_ready;

`ifdef BOOTH_MUL_SEQ_ZERO_SKIP_EN
  assign zero_op = (bus.op_a == '0) | (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Adder MSB alone is wrong on overflow; xor with ovfl gives the true sign.
  assign sgn       = bus.add_s[WIDTH-1] ^ bus.add_ovfl;
  assign acc_next  = {sgn, bus.add_s[WIDTH-1:1]};
  assign q_next    = {bus.add_s[0], q[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH-1));
  assign bus.prod  = prod_q;

  always_comb begin
    state_d         = state_q;
    bus.start_ready = 1'b0;
    bus.prod_valid  = 1'b0;
    bus.busy        = 1'b0;
    bus.add_a       = '0;
    bus.add_b       = '0;
    bus.add_cin     = 1'b0;
    bus.add_is_sub  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) state_d = zero_op ? DONE : RUN;
      end
      RUN: begin
        bus.busy       = 1'b1;
        bus.add_a      = acc;
        bus.add_b      = sel_mcand ? mcand : '0;
        bus.add_is_sub = step_sub;
        bus.add_cin    = step_sub;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        bus.busy       = 1'b1;
        bus.prod_valid = 1'b1;
        if (bus.prod_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          mcand <= bus.op_a;
          q     <= bus.op_b;
          acc   <= '0;
          q_m1  <= 1'b0;
          cnt   <= '0;
          if (zero_op) prod_q <= '0;
        end
        RUN: begin
          acc  <= acc_next;
          q    <= q_next;
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          if (last_step) prod_q <= {acc_next, q_next};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed, table-driven bench for booth_mul_seq with a behavioural CLA add/sub model.
module tb_booth_mul_seq;

  localparam int W = 16;
`ifdef BOOTH_MUL_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  booth_mul_seq_if #(.WIDTH(W)) bus ();

  booth_mul_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared adder: S = A + (isSub ? ~B : B) + Cin, signed overflow flag.
  logic [W-1:0] bb;
  logic [W:0]   sum;
  always_comb begin
    bb           = bus.add_is_sub ? ~bus.add_b : bus.add_b;
    sum          = {1'b0, bus.add_a} + {1'b0, bb} + {{W{1'b0}}, bus.add_cin};
    bus.add_s    = sum[W-1:0];
    bus.add_ovfl = (bus.add_a[W-1] == bb[W-1]) && (sum[W-1] != bus.add_a[W-1]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command; lat counts clock edges from the accepting edge to prod_valid.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic rdy,
                         output int lat, output logic [31:0] p);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.start_valid = 1'b1; bus.prod_ready = rdy;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
    lat = 1;
    while (!bus.prod_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    p = bus.prod;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    logic [31:0] p;

    vecs[0] = '{16'h0003, 16'h0004, 32'h0000000C};
    vecs[1] = '{16'hFFFD, 16'h0004, 32'hFFFFFFF4};
    vecs[2] = '{16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[7] = '{16'h1234, 16'hFFFE, 32'hFFFFDB98};
    vecs[8] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[9] = '{16'h00FF, 16'h0100, 32'h0000FF00};

    bus.start_valid = 1'b0; bus.prod_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset start_ready", 32'(bus.start_ready), 32'd1);
    check("reset prod_valid",  32'(bus.prod_valid),  32'd0);
    check("reset prod",        bus.prod,             32'd0);
    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset add_a",       32'(bus.add_a),       32'd0);

    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, 1'b1, lat, p);
      check($sformatf("vec%0d prod", i), p, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(W + 1));
      check($sformatf("vec%0d done adder idle", i), 32'({bus.add_b, bus.add_is_sub}), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d pulse width", i), 32'(bus.prod_valid), 32'd0);
      check($sformatf("vec%0d back to idle", i), 32'(bus.start_ready), 32'd1);
    end

    // Backpressure: hold DONE, try to start a new command meanwhile.
    run_mul(16'h0007, 16'hFFFA, 1'b0, lat, p);
    check("bp prod", p, 32'hFFFFFFD6);
    bus.op_a = 16'h0002; bus.op_b = 16'h0002; bus.start_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp prod_valid held", 32'(bus.prod_valid), 32'd1);
      check("bp prod held", bus.prod, 32'hFFFFFFD6);
      check("bp start_ready low", 32'(bus.start_ready), 32'd0);
      check("bp busy", 32'(bus.busy), 32'd1);
    end
    bus.start_valid = 1'b0;
    bus.prod_ready  = 1'b1;
    @(negedge clk);
    check("bp release prod_valid", 32'(bus.prod_valid), 32'd0);
    check("bp release start_ready", 32'(bus.start_ready), 32'd1);
    check("bp release busy", 32'(bus.busy), 32'd0);

    // Reset mid-RUN discards the product.
    @(negedge clk);
    bus.op_a = 16'h0100; bus.op_b = 16'h0100; bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid-run busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid-run start_ready", 32'(bus.start_ready), 32'd1);
    check("rst mid-run prod", bus.prod, 32'd0);
    check("rst mid-run busy", 32'(bus.busy), 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.prod_valid) seen++;
      end
      check("rst mid-run no prod_valid", 32'(seen), 32'd0);
    end
    run_mul(16'h0005, 16'h0005, 1'b1, lat, p);
    check("after rst prod", p, 32'h00000019);
    check("after rst latency", 32'(lat), 32'(W + 1));

    // Zero operand: immediate with skip enabled, full run otherwise.
    @(negedge clk);
    run_mul(16'h1234, 16'h0000, 1'b1, lat, p);
    check("zero prod", p, 32'd0);
    check("zero latency", 32'(lat), 32'(ZERO_LAT));
    @(negedge clk);
    check("zero back to idle", 32'(bus.start_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
